// File: rtl/closest_hit_tracker_pkg.sv
// Shared ray-tracing types: Q16.16 fixed point, 3-vectors, tracker FSM states and hit records.
package rt_pkg;

  typedef logic signed [31:0] fip32_t;
  typedef fip32_t [0:2] vec3_t;

  localparam fip32_t FIP_ONE = 32'sh00010000;
  localparam fip32_t FIP_MAX = 32'sh7FFFFFFF;
  localparam int TRI_ID_W_DFLT = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } trk_state_t;

  typedef struct packed {
    logic                     hit;
    fip32_t                   t;
    vec3_t                    normal;
    logic [TRI_ID_W_DFLT-1:0] tri_id;
  } hit_rec_t;

endpackage

// File: rtl/closest_hit_tracker_if.sv
// Beat-in / record-out handshake bundle between intersection stage, tracker and shading stage.
interface closest_hit_tracker_if
  import rt_pkg::*;
#(
  parameter int TRI_ID_W = 16,
  parameter int CNT_W    = 8
);
  logic                i_valid;
  logic                o_ready;
  logic                i_hit;
  logic                i_invalid;
  fip32_t              i_t;
  vec3_t               i_normal;
  logic [TRI_ID_W-1:0] i_tri_id;
  logic                i_last;

  logic                o_valid;
  logic                i_ready;
  logic                o_hit;
  fip32_t              o_t;
  vec3_t               o_normal;
  logic [TRI_ID_W-1:0] o_tri_id;
  logic [CNT_W-1:0]    o_invalid_cnt;

  // master: the environment feeding beats and consuming records
  modport master (
    output i_valid, i_hit, i_invalid, i_t, i_normal, i_tri_id, i_last, i_ready,
    input  o_ready, o_valid, o_hit, o_t, o_normal, o_tri_id, o_invalid_cnt
  );

  modport slave (
    input  i_valid, i_hit, i_invalid, i_t, i_normal, i_tri_id, i_last, i_ready,
    output o_ready, o_valid, o_hit, o_t, o_normal, o_tri_id, o_invalid_cnt
  );
endinterface

// File: rtl/closest_hit_tracker_hit_compare.sv
// Combinational qualify/select of one intersection beat against the running best hit.
module hit_compare
  import rt_pkg::*;
#(
  parameter int TRI_ID_W = 16
) (
  input  logic                beat_hit,
  input  logic                beat_invalid,
  input  fip32_t              beat_t,
  input  vec3_t               beat_normal,
  input  logic [TRI_ID_W-1:0] beat_tri_id,
  input  logic                best_hit,
  input  fip32_t              best_t,
  input  vec3_t               best_normal,
  input  logic [TRI_ID_W-1:0] best_tri_id,
  output logic                qualify,
  output logic                sel_hit,
  output fip32_t              sel_t,
  output vec3_t               sel_normal,
  output logic [TRI_ID_W-1:0] sel_tri_id
);

  // Strict less-than so an equal-distance later triangle never displaces the earlier one.
  assign qualify    = beat_hit & ~beat_invalid & (beat_t < best_t);
  assign sel_hit    = qualify ? 1'b1        : best_hit;
  assign sel_t      = qualify ? beat_t      : best_t;
  assign sel_normal = qualify ? beat_normal : best_normal;
  assign sel_tri_id = qualify ? beat_tri_id : best_tri_id;

endmodule

// File: rtl/closest_hit_tracker.sv
// Reduces a ray's stream of triangle tests to its nearest valid hit; one record per ray.
// state | meaning
// ACCUM | accepting beats, folding each into the running best
// EMIT  | holding the finished record until the shading stage takes it
module closest_hit_tracker
  import rt_pkg::*;
#(
  parameter int     TRI_ID_W = 16,
  parameter int     CNT_W    = 8,
  parameter fip32_t T_INIT   = FIP_MAX
) (
  input logic i_clk,
  input logic i_reset,
  closest_hit_tracker_if.slave bus
);

  trk_state_t          state_q, state_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                best_hit_q, best_hit_d;
  fip32_t              best_t_q, best_t_d;
  vec3_t               best_normal_q, best_normal_d;
  logic [TRI_ID_W-1:0] best_tri_id_q, best_tri_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                qualify;
  logic                sel_hit;
  fip32_t              sel_t;
  vec3_t               sel_normal;
  logic [TRI_ID_W-1:0] sel_tri_id;

  hit_compare #(.TRI_ID_W(TRI_ID_W)) u_cmp (
    .beat_hit     (bus.i_hit),
    .beat_invalid (bus.i_invalid),
    .beat_t       (bus.i_t),
    .beat_normal  (bus.i_normal),
    .beat_tri_id  (bus.i_tri_id),
    .best_hit     (best_hit_q),
    .best_t       (best_t_q),
    .best_normal  (best_normal_q),
    .best_tri_id  (best_tri_id_q),
    .qualify      (qualify),
    .sel_hit      (sel_hit),
    .sel_t        (sel_t),
    .sel_normal   (sel_normal),
    .sel_tri_id   (sel_tri_id)
  );

  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    valid_d       = valid_q;
    best_hit_d    = best_hit_q;
    best_t_d      = best_t_q;
    best_normal_d = best_normal_q;
    best_tri_id_d = best_tri_id_q;
    cnt_d         = cnt_q;
    case (state_q)
      ACCUM: begin
        if (bus.i_valid && ready_q) begin
          best_hit_d    = sel_hit;
          best_t_d      = sel_t;
          best_normal_d = sel_normal;
          best_tri_id_d = sel_tri_id;
          if (bus.i_invalid && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
          if (bus.i_last) begin
            state_d = EMIT;
            valid_d = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      EMIT: begin
        if (bus.i_ready) begin
          state_d       = ACCUM;
          valid_d       = 1'b0;
          ready_d       = 1'b1;
          best_hit_d    = 1'b0;
          best_t_d      = T_INIT;
          best_normal_d = '0;
          best_tri_id_d = '0;
          cnt_d         = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ACCUM;
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      best_hit_q    <= 1'b0;
      best_t_q      <= T_INIT;
      best_normal_q <= '0;
      best_tri_id_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      valid_q       <= valid_d;
      best_hit_q    <= best_hit_d;
      best_t_q      <= best_t_d;
      best_normal_q <= best_normal_d;
      best_tri_id_q <= best_tri_id_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs come straight from the running best; it is frozen while in EMIT.
  assign bus.o_ready       = ready_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_hit         = best_hit_q;
  assign bus.o_t           = best_t_q;
  assign bus.o_normal      = best_normal_q;
  assign bus.o_tri_id      = best_tri_id_q;
  assign bus.o_invalid_cnt = cnt_q;

endmodule
